// File: rtl/psum_pkg.sv
// Shared widths, FSM states and the per-word requantiser for the psum writer.
// Pure definitions: no state, no timing.
package psum_pkg;

    localparam int C_WIDTH          = 32;
    localparam int C_WORDS_PER_BEAT = 4;
    localparam int OUT_WIDTH        = 8;
    localparam int FIFO_DEPTH       = 16;
    localparam int ADDR_WIDTH       = 16;
    localparam int SHIFT_WIDTH      = 5;
    localparam int IN_BEAT_W        = C_WIDTH * C_WORDS_PER_BEAT;
    localparam int OUT_BEAT_W       = OUT_WIDTH * C_WORDS_PER_BEAT;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Rounding arithmetic shift, optional ReLU, then saturation. One extra bit
    // of headroom keeps the +1 rounding from wrapping at the positive limit.
    function automatic logic [OUT_WIDTH-1:0] requant(
        input logic [C_WIDTH-1:0]     x,
        input logic [SHIFT_WIDTH-1:0] shift,
        input logic                   relu
    );
        logic signed [C_WIDTH:0]  xe;
        logic signed [C_WIDTH:0]  shifted;
        logic signed [C_WIDTH:0]  rounded;
        logic signed [C_WIDTH:0]  max_v;
        logic signed [C_WIDTH:0]  min_v;
        logic [SHIFT_WIDTH-1:0]   rbit_idx;
        logic                     rbit;

        xe       = $signed({x[C_WIDTH-1], x});
        shifted  = xe >>> shift;
        rbit_idx = shift - 1'b1;
        rbit     = (shift != '0) && x[rbit_idx];
        rounded  = shifted + $signed({{C_WIDTH{1'b0}}, rbit});
        max_v    = $signed({{(C_WIDTH-OUT_WIDTH+2){1'b0}}, {(OUT_WIDTH-1){1'b1}}});
        min_v    = ~max_v;

        if (relu && rounded[C_WIDTH]) begin
            rounded = '0;
        end
        if (rounded > max_v) begin
            rounded = max_v;
        end else if (rounded < min_v) begin
            rounded = min_v;
        end
        return rounded[OUT_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational read data valid whenever !empty_o.
// Push while full is accepted only together with a pop; pop while empty is ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_dat_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         pop_dat_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             push_ok;
    logic             pop_ok;

    assign empty_o   = (count_q == '0);
    assign full_o    = (count_q == (AW+1)'(DEPTH));
    assign count_o   = count_q;
    assign pop_dat_o = mem_q[rd_ptr_q];
    assign pop_ok    = pop_i && !empty_o;
    assign push_ok   = push_i && (!full_o || pop_ok);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

endmodule

// File: rtl/psum_writer.sv
// Buffers array psum beats, requantises them and streams them out with sequential addresses.
// Latency 2 cycles in->out; the array cannot stall, so beats arriving to a full FIFO are dropped.
module psum_writer
    import psum_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_start,
    input  logic [31:0]           cfg_total_beats,
    input  logic [ADDR_WIDTH-1:0] cfg_base_addr,
    input  logic [4:0]            cfg_shift,
    input  logic                  cfg_relu,
    input  logic                  in_valid,
    input  logic [IN_BEAT_W-1:0]  in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OUT_BEAT_W-1:0] out_data,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_t                state_q, state_d;
    logic [31:0]           total_q, total_d;
    logic [31:0]           accepted_q, accepted_d;
    logic [4:0]            shift_q, shift_d;
    logic                  relu_q, relu_d;
    logic                  overflow_q, overflow_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  out_valid_q, out_valid_d;
    logic [OUT_BEAT_W-1:0] out_data_q, out_data_d;

    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [CW-1:0]         fifo_count;
    logic [IN_BEAT_W-1:0]  fifo_dat;
    logic [OUT_BEAT_W-1:0] head_rq;
    logic                  in_run;

    sync_fifo #(
        .WIDTH (IN_BEAT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (fifo_push),
        .push_dat_i (in_data),
        .pop_i      (fifo_pop),
        .pop_dat_o  (fifo_dat),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .count_o    (fifo_count)
    );

    // The out register refills from the FIFO head whenever it is free or being drained.
    assign in_run    = (state_q == RUN);
    assign fifo_pop  = !fifo_empty && (!out_valid_q || out_ready);
    assign fifo_push = in_run && in_valid && (!fifo_full || fifo_pop);

    always_comb begin
        head_rq = '0;
        for (int v = 0; v < C_WORDS_PER_BEAT; v++) begin
            head_rq[v*OUT_WIDTH +: OUT_WIDTH] =
                requant(fifo_dat[v*C_WIDTH +: C_WIDTH], shift_q, relu_q);
        end
    end

    always_comb begin
        state_d     = state_q;
        total_d     = total_q;
        accepted_d  = accepted_q;
        shift_d     = shift_q;
        relu_d      = relu_q;
        overflow_d  = overflow_q;
        addr_d      = addr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
            addr_d      = addr_q + 1'b1;
        end
        if (fifo_pop) begin
            out_valid_d = 1'b1;
            out_data_d  = head_rq;
        end
        if (fifo_push) begin
            accepted_d = accepted_q + 32'd1;
        end
        if (in_run && in_valid && !fifo_push) begin
            overflow_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (cfg_start) begin
                    total_d    = cfg_total_beats;
                    shift_d    = cfg_shift;
                    relu_d     = cfg_relu;
                    accepted_d = '0;
                    overflow_d = 1'b0;
                    addr_d     = cfg_base_addr;
                    state_d    = (cfg_total_beats == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (accepted_d == total_q) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Leave as soon as the last beat is handed off, not a cycle later.
                if ((fifo_count == '0) && !out_valid_d) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            total_q     <= '0;
            accepted_q  <= '0;
            shift_q     <= '0;
            relu_q      <= 1'b0;
            overflow_q  <= 1'b0;
            addr_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            total_q     <= total_d;
            accepted_q  <= accepted_d;
            shift_q     <= shift_d;
            relu_q      <= relu_d;
            overflow_q  <= overflow_d;
            addr_q      <= addr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_addr  = addr_q;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign overflow  = overflow_q;

endmodule
